// File: rtl/uart_tx_drain_if.sv
// Read port of the byte FIFO as seen by the UART transmitter that drains it.
// master is the consumer (issues pops), slave is the FIFO.
interface uart_tx_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from a registered-read FIFO and serialises them
// LSB-first with start, optional parity and 1 or 2 stop bits, back-to-back while data remains.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en,
  uart_tx_drain_if.master fifo,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shreg_sh;
  logic                  par_q, par_d;
  logic                  last_tick;

  assign last_tick = (cnt_q == CNT_LAST);
  assign shreg_sh  = shreg_q >> 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo.fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end

      // Pop is sampled by the FIFO at the end of this cycle.
      FETCH: begin
        state_d = LOAD;
      end

      // fifo_dout is valid now, one cycle after the pop was sampled.
      LOAD: begin
        shreg_d = fifo.fifo_dout;
        par_d   = frame_parity(fifo.fifo_dout);
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end

      START: begin
        if (last_tick) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (last_tick) begin
          cnt_d   = '0;
          shreg_d = shreg_sh;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shreg_sh[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (last_tick) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // idx counts stop bits here; the final one returns to IDLE with the done pulse.
      STOP: begin
        if (last_tick) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  // Shift register and parity are only read after LOAD, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  assign tx              = tx_q;
  assign frame_done      = done_q;
  assign busy            = (state_q != IDLE);
  assign fifo.fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three instances (8N1, 8E2, 8O1 at 4 clocks per bit) fed by
// queue-backed FIFO stubs, checked every cycle against a frame-timeline model.
module tb_uart_tx_drain;
  localparam int N   = 3;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic tx_en = 1'b0;
  logic [N-1:0] tx_w, busy_w, done_w, rd_w;

  logic [7:0] fmem [N][32];
  int         f_wp [N] = '{default: 0};
  int         f_rp [N] = '{default: 0};
  logic [7:0] f_dout [N];
  int         pops [N] = '{default: 0};
  int         m_t  [N] = '{default: 0};
  int         m_rp [N] = '{default: 0};
  logic [7:0] m_byte [N];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    uart_tx_drain_if #(.DATA_WIDTH(8)) fif ();
    assign fif.fifo_empty = (f_wp[gi] == f_rp[gi]);
    assign fif.fifo_dout  = f_dout[gi];
    assign rd_w[gi]       = fif.fifo_rd_en;

    uart_tx_drain #(
      .CLKS_PER_BIT(CPB),
      .DATA_WIDTH  (8),
      .PARITY_EN   ((gi == 0) ? 0 : 1),
      .PARITY_ODD  ((gi == 2) ? 1 : 0),
      .STOP_BITS   ((gi == 1) ? 2 : 1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .fifo      (fif),
      .tx        (tx_w[gi]),
      .busy      (busy_w[gi]),
      .frame_done(done_w[gi])
    );
  end

  // Frame timeline: t=1 pop cycle, t=2 load, t=3.. bits, t=frame_end is the done cycle.
  function automatic int nbits(input int g);
    return 1 + 8 + ((g == 0) ? 0 : 1) + ((g == 1) ? 2 : 1);
  endfunction

  function automatic int frame_end(input int g);
    return 3 + nbits(g) * CPB;
  endfunction

  function automatic logic exp_tx(input int g, input int t, input logic [7:0] b);
    int k;
    if (t < 3 || t >= frame_end(g)) return 1'b1;
    k = (t - 3) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (g != 0 && k == 9) return (^b) ^ (g == 2);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < N; g++)
      if (rd_w[g]) pops[g] <= pops[g] + 1;
  end

  // FIFO stubs (registered read, cleared by rst) and the reference timeline.
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        f_rp[g] <= f_wp[g];
        m_rp[g] <= f_wp[g];
        m_t[g]  <= 0;
      end else begin
        if (rd_w[g] && (f_rp[g] != f_wp[g])) begin
          f_dout[g] <= fmem[g][f_rp[g][4:0]];
          f_rp[g]   <= f_rp[g] + 1;
        end
        if (m_t[g] == 0 || m_t[g] == frame_end(g)) begin
          if (tx_en && (m_rp[g] != f_wp[g])) begin
            m_byte[g] <= fmem[g][m_rp[g][4:0]];
            m_rp[g]   <= m_rp[g] + 1;
            m_t[g]    <= 1;
          end else begin
            m_t[g] <= 0;
          end
        end else begin
          m_t[g] <= m_t[g] + 1;
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    fmem[g][f_wp[g][4:0]] = b;
    f_wp[g] = f_wp[g] + 1;
  endtask

  task automatic monitor();
    int t;
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        t = m_t[g];
        chk1($sformatf("tx_%0d", g), tx_w[g], exp_tx(g, t, m_byte[g]));
        chk1($sformatf("busy_%0d", g), busy_w[g], (t >= 1) && (t < frame_end(g)));
        chk1($sformatf("rd_en_%0d", g), rd_w[g], t == 1);
        chk1($sformatf("frame_done_%0d", g), done_w[g], t == frame_end(g));
      end
    end
  endtask

  task automatic wait_start(input int g, output int ts);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_w[g] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("start_seen_%0d", g), tx_w[g], 1'b0);
    ts = cyc;
  endtask

  task automatic wait_done(input int g, output int td);
    int n;
    n = 0;
    @(negedge clk);
    while (done_w[g] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("done_seen_%0d", g), done_w[g], 1'b1);
    td = cyc;
  endtask

  // Samples each bit in its third cycle; seq[k] is bit k of the frame (seq[0] = start).
  task automatic rx_frame(input int g, input int nb, input int drop_k,
                          output logic [15:0] seq, output int ts);
    seq = '0;
    wait_start(g, ts);
    repeat (2) @(negedge clk);
    seq[0] = tx_w[g];
    for (int k = 1; k < nb; k++) begin
      repeat (CPB) @(negedge clk);
      seq[k] = tx_w[g];
      if (k == drop_k) tx_en = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] seq;
    int t0, ts, ts2, td, p0, lows, dn;

    rst   = 1'b1;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk1("reset_tx", tx_w[0], 1'b1);
    chk1("reset_busy", busy_w[0], 1'b0);
    chk1("reset_rd_en", rd_w[0], 1'b0);
    chk1("reset_done", done_w[0], 1'b0);
    fork
      monitor();
    join_none
    rst = 1'b0;
    @(negedge clk);

    // single 8N1 frame of 0xA5
    p0 = pops[0];
    push(0, 8'hA5);
    tx_en = 1'b1;
    t0 = cyc;
    @(negedge clk);
    chk1("t1_pop_strobe", rd_w[0], 1'b1);
    @(negedge clk);
    chk1("t1_pop_one_cycle", rd_w[0], 1'b0);
    rx_frame(0, 10, -1, seq, ts);
    chkn("t1_latency", ts - t0, 3);
    chkn("t1_bits", int'(seq[9:0]), 'h34A);
    wait_done(0, td);
    chkn("t1_done_time", td - t0, 43);
    chkn("t1_pops", pops[0] - p0, 1);
    chkn("t1_fifo_empty", f_wp[0] - f_rp[0], 0);

    // three back-to-back frames
    @(negedge clk);
    p0 = pops[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    rx_frame(0, 10, -1, seq, ts);
    chkn("t2_byte0", int'(seq[8:1]), 'h00);
    chk1("t2_stop0", seq[9], 1'b1);
    rx_frame(0, 10, -1, seq, ts2);
    chkn("t2_byte1", int'(seq[8:1]), 'hFF);
    chkn("t2_period01", ts2 - ts, 43);
    ts = ts2;
    rx_frame(0, 10, -1, seq, ts2);
    chkn("t2_byte2", int'(seq[8:1]), 'h3C);
    chkn("t2_period12", ts2 - ts, 43);
    wait_done(0, td);
    chkn("t2_pops", pops[0] - p0, 3);
    chkn("t2_fifo_empty", f_wp[0] - f_rp[0], 0);

    // even parity, two stop bits
    push(1, 8'hA5);
    push(1, 8'h07);
    rx_frame(1, 12, -1, seq, ts);
    chkn("t3_even_a5_data", int'(seq[8:1]), 'hA5);
    chk1("t3_even_a5_parity", seq[9], 1'b0);
    chkn("t3_even_stops", int'(seq[11:10]), 3);
    rx_frame(1, 12, -1, seq, ts2);
    chkn("t3_even_07_data", int'(seq[8:1]), 'h07);
    chk1("t3_even_07_parity", seq[9], 1'b1);
    chkn("t3_even_period", ts2 - ts, 51);
    wait_done(1, td);
    chkn("t3_even_frame_len", td - ts2, 48);

    // odd parity, one stop bit
    push(2, 8'hA5);
    push(2, 8'h07);
    rx_frame(2, 11, -1, seq, ts);
    chk1("t3_odd_a5_parity", seq[9], 1'b1);
    rx_frame(2, 11, -1, seq, ts2);
    chk1("t3_odd_07_parity", seq[9], 1'b0);
    chkn("t3_odd_period", ts2 - ts, 47);
    wait_done(2, td);
    chkn("t3_odd_frame_len", td - ts2, 44);

    // tx_en gating and mid-frame drop
    @(negedge clk);
    tx_en = 1'b0;
    p0 = pops[0];
    push(0, 8'h5A);
    push(0, 8'hC3);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
    end
    chkn("t4_disabled_low_cycles", lows, 0);
    chkn("t4_disabled_pops", pops[0] - p0, 0);
    tx_en = 1'b1;
    t0 = cyc;
    rx_frame(0, 10, 3, seq, ts);
    chkn("t4_latency", ts - t0, 3);
    chkn("t4_byte", int'(seq[8:1]), 'h5A);
    wait_done(0, td);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
    end
    chkn("t4_after_drop_low_cycles", lows, 0);
    chkn("t4_single_pop", pops[0] - p0, 1);
    chkn("t4_byte_left_queued", f_wp[0] - f_rp[0], 1);

    // reset during the 4th data bit of 0xC3
    tx_en = 1'b1;
    t0 = cyc;
    wait_start(0, ts);
    chkn("t5_latency", ts - t0, 3);
    repeat (2 + 4 * CPB) @(negedge clk);
    chk1("t5_busy_before_rst", busy_w[0], 1'b1);
    chk1("t5_data_bit3", tx_w[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("t5_rst_tx", tx_w[0], 1'b1);
    chk1("t5_rst_busy", busy_w[0], 1'b0);
    chk1("t5_rst_rd_en", rd_w[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
      if (done_w[0] === 1'b1) dn++;
    end
    chkn("t5_post_rst_low_cycles", lows, 0);
    chkn("t5_post_rst_done_pulses", dn, 0);
    chkn("t5_fifo_cleared", f_wp[0] - f_rp[0], 0);

    // push into an empty FIFO while idle and enabled
    p0 = pops[0];
    repeat (20) @(negedge clk);
    chkn("t6_no_pop_while_empty", pops[0] - p0, 0);
    push(0, 8'h96);
    t0 = cyc;
    @(negedge clk);
    chk1("t6_pop_next_edge", rd_w[0], 1'b1);
    rx_frame(0, 10, -1, seq, ts);
    chkn("t6_latency", ts - t0, 3);
    chkn("t6_byte", int'(seq[8:1]), 'h96);
    wait_done(0, td);
    chkn("t6_pops", pops[0] - p0, 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
UART transmitter that sits directly downstream of the byte FIFO. It pops one word at a time through the FIFO read port, serialises it onto the tx line LSB-first, and adds start, optional parity and stop bits. It tolerates the FIFO's one-cycle registered read latency. Frames go out back-to-back while the FIFO holds data and tx_en is high.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit; legal values are 2 or more (868 gives 115200 baud at 100 MHz).
DATA_WIDTH, 8, data bits per frame; must equal the FIFO WIDTH.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
tx_en  input  1  while high, new frames may start; a frame already in flight always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en is sampled.
fifo_rd_en  output  1  registered, one-cycle pop strobe to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
frame_done  output  1  registered one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset, asynchronous and effective immediately: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, baud counter=0, bit index=0. A frame in flight is abandoned and its byte is lost. The FIFO is reset from the same rst.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0, the next edge sets fifo_rd_en=1 and state=FETCH. Otherwise the block stays in IDLE.
- FETCH: lasts exactly 1 cycle with fifo_rd_en=1. The FIFO samples the pop at the end of this cycle. Next edge: fifo_rd_en=0, state=LOAD.
- LOAD: lasts 1 cycle while fifo_dout settles. Next edge: shift register <= fifo_dout, parity bit computed, tx<=0, state=START, counter=0.
- Bit timing: every bit holds tx for exactly CLKS_PER_BIT cycles. The counter counts 0..CLKS_PER_BIT-1; the state or bit advances on the edge where counter==CLKS_PER_BIT-1.
- START: tx=0 for one bit time, then DATA with bit index 0.
- DATA: tx=shreg[0] for one bit time, then shift right. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: tx = XOR of the data bits, XOR PARITY_ODD.
- STOP: tx=1 for STOP_BITS bit times. On the final edge: state=IDLE and frame_done=1 for exactly one cycle.
- Latency: from the IDLE cycle that sees fifo_empty=0 to tx falling is 3 edges.
- Back-to-back frames: tx stays high for 3 cycles between the end of stop and the next start. Frame period = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT + 3 cycles.
- fifo_rd_en is never asserted outside FETCH, so there is exactly one pop per frame. fifo_empty and tx_en are ignored outside IDLE.
- tx_en falling mid-frame has no effect on that frame. The block then stays in IDLE after frame_done.
- fifo_empty rising during FETCH or LOAD is illegal. This block is the FIFO's only consumer, so it cannot occur.
- busy is decoded from state: 1 in FETCH through STOP.

Test Plan:
1. CLKS_PER_BIT=4, no parity, 1 stop. Push 0xA5; tx_en=1 -> fifo_rd_en pulses for 1 cycle. tx falls 3 edges later. tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. frame_done pulses once. The FIFO reports empty.
2. Push 0x00, 0xFF, 0x3C with no gaps -> three frames, each 40 cycles long, separated by exactly 3 idle-high cycles. Exactly 3 pops occur. Decoded bytes match in order.
3. PARITY_EN=1 with byte 0xA5 (four ones) -> parity bit 0 for even, 1 for PARITY_ODD=1. Byte 0x07 -> parity bit 1 for even, 0 for odd. With STOP_BITS=2 the stop time is 8 cycles.
4. tx_en=0 with 2 bytes queued -> no pop and tx stays at 1 for 100 cycles. Raise tx_en -> transmission starts 3 edges later. Drop tx_en during DATA -> the current frame completes and no second pop occurs.
5. Assert rst during the 4th data bit -> within the same cycle tx=1, busy=0, fifo_rd_en=0. After release with an empty FIFO, tx remains 1 and no frame_done pulse occurs.
6. Push a byte while the FIFO is empty, in the same cycle the block is in IDLE -> the pop is issued on the edge after fifo_empty falls. No spurious pop occurs while fifo_empty=1.
